store_buffer: RTL

//  Posted-store buffer between the MEM-stage pipeline register and the byte-addressed data memory.

---
 rtl/store_buffer.sv | 165 ++++++++++++++++
 1 files changed

// File: rtl/store_buffer.sv
// Posted-store buffer between the MEM stage and a byte-addressed data memory.
// Stores queue in program order and drain in idle cycles; overlapping loads stall until drained.
module store_buffer #(
  parameter int DEPTH  = 4,
  parameter int ADDR_W = 32
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              req_valid,
  input  logic              req_read,
  input  logic              req_write,
  input  logic [2:0]        req_func3,
  input  logic [ADDR_W-1:0] req_addr,
  input  logic [31:0]       req_wdata,
  input  logic              fence,
  output logic              stall,
  output logic [31:0]       ld_data,
  output logic              empty,
  output logic              mem_read,
  output logic              mem_write,
  output logic [2:0]        mem_func3,
  output logic [ADDR_W-1:0] mem_addr,
  output logic [31:0]       mem_wdata,
  input  logic [31:0]       mem_rdata
);

  localparam int PW = $clog2(DEPTH);
  localparam int CW = PW + 1;

  logic [ADDR_W-1:0] r_addr  [DEPTH];
  logic [2:0]        r_func3 [DEPTH];
  logic [31:0]       r_wdata [DEPTH];
  logic [PW-1:0]     r_head;
  logic [PW-1:0]     r_tail;
  logic [CW-1:0]     r_count;

  logic              w_load;
  logic              w_store;
  logic              w_full;
  logic              w_nonempty;
  logic              w_hazard;
  logic              w_stall;
  logic              w_drain;
  logic              w_rd;
  logic              w_enq;
  logic [ADDR_W-1:0] w_ld_last;

  // Address of the last byte touched by an access of the given width.
  function automatic logic [ADDR_W-1:0] last_byte(input logic [ADDR_W-1:0] a, input logic [2:0] f3);
    case (f3[1:0])
      2'd0:    last_byte = a;
      2'd1:    last_byte = a + ADDR_W'(1);
      default: last_byte = a + ADDR_W'(3);
    endcase
  endfunction

  // Word-level overlap of the incoming load against every live entry.
  always_comb begin
    logic [PW-1:0]     off;
    logic [ADDR_W-1:0] e_last;
    logic [ADDR_W-3:0] l_lo, l_hi, e_lo, e_hi;
    w_ld_last = last_byte(req_addr, req_func3);
    l_lo      = req_addr[ADDR_W-1:2];
    l_hi      = w_ld_last[ADDR_W-1:2];
    w_hazard  = 1'b0;
    for (int i = 0; i < DEPTH; i++) begin
      off    = PW'(i) - r_head;
      e_last = last_byte(r_addr[i], r_func3[i]);
      e_lo   = r_addr[i][ADDR_W-1:2];
      e_hi   = e_last[ADDR_W-1:2];
      if (({1'b0, off} < r_count) &&
          ((l_lo == e_lo) || (l_lo == e_hi) || (l_hi == e_lo) || (l_hi == e_hi))) begin
        w_hazard = 1'b1;
      end else begin
        w_hazard = w_hazard;
      end
    end
  end

  // Request arbitration; first matching rule wins, everything idles while in reset.
  always_comb begin
    w_load     = req_valid & req_read;
    w_store    = req_valid & req_write & ~req_read;
    w_full     = (r_count == CW'(DEPTH));
    w_nonempty = (r_count != {CW{1'b0}});
    w_stall    = 1'b0;
    w_drain    = 1'b0;
    w_rd       = 1'b0;
    w_enq      = 1'b0;
    if (!rst) begin
      w_stall = 1'b0;
    end else if (fence && w_nonempty) begin
      w_stall = 1'b1;
      w_drain = 1'b1;
    end else if (w_load && w_hazard) begin
      w_stall = 1'b1;
      w_drain = 1'b1;
    end else if (w_load) begin
      w_rd = 1'b1;
    end else if (w_store && w_full) begin
      w_stall = 1'b1;
      w_drain = 1'b1;
    end else if (w_store) begin
      w_enq = ~req_func3[2] & (req_func3[1:0] != 2'b11);
    end else if (w_nonempty) begin
      w_drain = 1'b1;
    end else begin
      w_drain = 1'b0;
    end
  end

  // Memory port and pipeline-facing outputs.
  always_comb begin
    stall     = w_stall;
    mem_read  = w_rd;
    mem_write = w_drain;
    empty     = (r_count == {CW{1'b0}});
    if (w_rd) begin
      mem_addr  = req_addr;
      mem_func3 = req_func3;
      mem_wdata = 32'h0000_0000;
      ld_data   = mem_rdata;
    end else if (w_drain) begin
      mem_addr  = r_addr[r_head];
      mem_func3 = r_func3[r_head];
      mem_wdata = r_wdata[r_head];
      ld_data   = 32'h0000_0000;
    end else begin
      mem_addr  = {ADDR_W{1'b0}};
      mem_func3 = 3'd0;
      mem_wdata = 32'h0000_0000;
      ld_data   = 32'h0000_0000;
    end
  end

  // FIFO state: pop on drain, push on accepted store.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      r_head  <= {PW{1'b0}};
      r_tail  <= {PW{1'b0}};
      r_count <= {CW{1'b0}};
      for (int i = 0; i < DEPTH; i++) begin
        r_addr[i]  <= {ADDR_W{1'b0}};
        r_func3[i] <= 3'd0;
        r_wdata[i] <= 32'h0000_0000;
      end
    end else begin
      if (w_drain) begin
        r_head <= r_head + PW'(1);
      end
      if (w_enq) begin
        r_addr[r_tail]  <= req_addr;
        r_func3[r_tail] <= req_func3;
        r_wdata[r_tail] <= req_wdata;
        r_tail          <= r_tail + PW'(1);
      end
      case ({w_enq, w_drain})
        2'b10:   r_count <= r_count + CW'(1);
        2'b01:   r_count <= r_count - CW'(1);
        default: r_count <= r_count;
      endcase
    end
  end

endmodule
